// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between IF fetches and MEM accesses, data first
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_ready,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [3:0]        data_sel,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ready,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              stallreq_if,
  output logic              stallreq_mem
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] INST  = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;
  logic [2:0] state;
  logic       srv_data;
  // Ready is a RESP-cycle pulse that a same-cycle flush can still cancel
  always_comb begin
    inst_ready   = state == RESP && !srv_data && !flush;
    data_ready   = state == RESP && srv_data && !flush;
    stallreq_if  = inst_req && !inst_ready;
    stallreq_mem = data_req && !data_ready;
  end
  // Transaction sequencing: start in IDLE, wait for ack, drain if flushed, respond once
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      srv_data   <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_sel    <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (!flush && (data_req || inst_req)) begin
          state    <= data_req ? DATA : INST;
          srv_data <= data_req;
          bus_req  <= 1'b1;
          bus_we   <= data_req && data_we;
          bus_sel  <= data_req ? data_sel : 4'hf;
          bus_addr <= data_req ? data_addr : inst_addr;
          if (data_req) bus_wdata <= data_wdata;
        end
        INST, DATA: if (bus_ack) begin
          bus_req <= 1'b0;
          state   <= flush ? IDLE : RESP;
          if (!flush && !bus_we) begin
            if (srv_data) data_rdata <= bus_rdata;
            else inst_rdata <= bus_rdata;
          end
        end else if (flush) state <= DRAIN;
        DRAIN: if (bus_ack) begin
          bus_req <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
